sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single on-chip SRAM port in soc_top between two requesters.
  - M0: cpu_top instruction fetch.
  - M1: cpu_top load/store unit.
- One transaction is outstanding at a time.
- Arbitration is data-priority, with a starvation limiter so fetch always makes progress.
- A response timeout returns an error so a hung slave cannot deadlock the pipeline.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- STARVE_LIM, 4, max consecutive M1 grants while M0 is requesting; range 1..15.
- TIMEOUT, 255, max cycles spent in REQ+RESP before an error response; range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  fetch request; held with address until m0_gnt
- m0_addr  in  AW  fetch address
- m0_gnt  out  1  fetch request accepted, 1-cycle pulse
- m0_rvalid  out  1  fetch response, 1-cycle pulse
- m0_rdata  out  DW  fetch read data
- m0_rerr  out  1  fetch timeout error, qualified by m0_rvalid
- m1_req  in  1  load/store request; held until m1_gnt
- m1_we  in  1  1 = write
- m1_addr  in  AW  data address
- m1_wdata  in  DW  write data
- m1_wstrb  in  DW/8  byte enables
- m1_gnt, m1_rvalid, m1_rdata, m1_rerr  out  1/1/DW/1  same meaning as the M0 signals
- s_req  out  1  slave request, registered
- s_we  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_wstrb  out  DW/8  slave byte enables
- s_gnt  in  1  slave accepts s_req
- s_rvalid  in  1  slave response; also the acknowledge for writes
- s_rdata  in  DW  slave read data

Behaviour:
- Clock and reset
  - Single clock domain: clk.
  - rst is synchronous, active-high.
  - All registered outputs are 0 in reset: s_req, s_we, s_addr, s_wdata, s_wstrb.
  - m*_gnt, m*_rvalid, m*_rerr are 0 in reset.
  - State resets to IDLE; owner, starve_cnt and tmo_cnt reset to 0.
- State IDLE
  - If any m*_req is high: pick a winner, assert winner's m*_gnt combinationally in that cycle.
  - Latch the winner's addr/we/wdata/wstrb into the s_* registers, record owner, go to REQ.
  - M0 transactions always drive s_we=0 and s_wstrb=0.
- State REQ
  - s_req=1.
  - On s_gnt=1: drop s_req on the next edge, go to RESP.
- State RESP
  - s_req=0.
  - On s_rvalid=1, drive combinationally in the same cycle: owner's m*_rvalid=1, m*_rdata=s_rdata, m*_rerr=0. Go to IDLE.
  - Non-owner rvalid is 0; non-owner rdata is 0.
- Latency
  - Request accepted in cycle t.
  - s_req is high from t+1.
  - With s_gnt at t+1 and s_rvalid at t+2, the master sees rvalid at t+2.
  - Back-to-back: the next grant is possible in the cycle after rvalid, i.e. 3-cycle throughput minimum.
- Arbitration in IDLE
  - Only one requester: it wins.
  - Both requesting: M1 wins unless starve_cnt == STARVE_LIM, in which case M0 wins.
  - starve_cnt increments (saturating at STARVE_LIM) on an M1 grant while m0_req=1.
  - starve_cnt clears on any M0 grant, and on an M1 grant with m0_req=0.
- Timeout
  - tmo_cnt clears on entry to REQ and increments each cycle in REQ/RESP.
  - When tmo_cnt == TIMEOUT-1 and neither s_gnt (in REQ) nor s_rvalid (in RESP) is present: pulse owner's rvalid with rerr=1, rdata=0; clear s_req; go to IDLE.
  - An s_rvalid/s_gnt arriving in the same cycle as the timeout takes precedence, giving a normal completion.
- Boundary conditions
  - s_rvalid or s_gnt outside the expected state is ignored.
  - The slave must not respond after a timeout.
  - Masters may drop m*_req before gnt; a request not yet granted is simply not served.
  - Reset mid-transaction abandons the transfer: no rvalid is issued and s_req drops on the reset edge.

Test Plan:
- Isolated fetch: m0_req, addr 0x0000_0100, slave gnt same cycle, rvalid next cycle with rdata 0x0000_0013 -> m0_gnt at t, s_req t+1, m0_rvalid t+2 with rdata 0x13, rerr=0; m1 outputs stay 0.
- Simultaneous requests: m0 at 0x200, m1 write 0x8000_0000, data 0xDEADBEEF, wstrb 0xF -> M1 served first (s_we=1, s_wdata=0xDEADBEEF); M0 granted in the IDLE after M1's rvalid.
- Starvation, STARVE_LIM=4: m1_req held high continuously and m0_req high -> grant order M1,M1,M1,M1,M0,M1...; starve_cnt returns to 0 after the M0 grant.
- Slave stall: s_gnt withheld 5 cycles, then rvalid 3 cycles later -> s_req held 6 cycles, s_addr stable throughout; single rvalid to owner with correct data.
- Timeout, TIMEOUT=16: s_gnt given, s_rvalid never arrives -> owner rvalid=1, rerr=1, rdata=0 exactly 16 cycles after entering REQ; then a new request is served normally.
- Reset in RESP: rst for 1 cycle, then s_rvalid pulsed -> no m*_rvalid; s_req=0; next m0_req granted immediately from IDLE.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for the shared on-chip SRAM port.
// M0 (instruction fetch) and M1 (load/store) share one slave port with one
// transaction outstanding. M1 has priority, but a starvation limiter forces an
// M0 grant after STARVE_LIM back-to-back M1 grants. A response timeout returns
// an error so that a hung slave cannot deadlock either master.
module sram_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rerr,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rerr,

    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_gnt,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_t;

    state_t     state;
    logic       owner;       // 0 = M0, 1 = M1
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;

    logic m0_win;
    logic m1_win;
    logic resp_ok;
    logic tmo_hit;
    logic tmo_err;
    logic rsp_fire;

    // Winner selection in IDLE; M0 only beats a concurrent M1 once starved.
    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (state == StIdle && !rst) begin
            if (m0_req && (!m1_req || starve_cnt == STARVE_MAX)) begin
                m0_win = 1'b1;
            end else if (m1_req) begin
                m1_win = 1'b1;
            end
        end
    end

    // Completion decode: a real slave response wins over a same-cycle timeout.
    always_comb begin
        resp_ok  = (state == StResp) && s_rvalid;
        tmo_hit  = (tmo_cnt == TMO_LAST);
        tmo_err  = tmo_hit && (((state == StReq) && !s_gnt) ||
                               ((state == StResp) && !s_rvalid));
        // Gated by rst so an abandoned transfer never reports a response.
        rsp_fire = (resp_ok || tmo_err) && !rst;
    end

    // Master-side response steering; the non-owner sees all zeros.
    always_comb begin
        m0_gnt    = m0_win;
        m1_gnt    = m1_win;
        m0_rvalid = rsp_fire && !owner;
        m1_rvalid = rsp_fire && owner;
        m0_rerr   = m0_rvalid && tmo_err;
        m1_rerr   = m1_rvalid && tmo_err;
        m0_rdata  = (m0_rvalid && resp_ok) ? s_rdata : '0;
        m1_rdata  = (m1_rvalid && resp_ok) ? s_rdata : '0;
    end

    // Transaction FSM with registered slave-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            s_req      <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (m0_win || m1_win) begin
                        state   <= StReq;
                        s_req   <= 1'b1;
                        tmo_cnt <= '0;
                        owner   <= m1_win;
                        if (m1_win) begin
                            s_we    <= m1_we;
                            s_addr  <= m1_addr;
                            s_wdata <= m1_wdata;
                            s_wstrb <= m1_wstrb;
                            if (m0_req) begin
                                if (starve_cnt != STARVE_MAX) begin
                                    starve_cnt <= starve_cnt + 4'd1;
                                end
                            end else begin
                                starve_cnt <= '0;
                            end
                        end else begin
                            // Fetches are always reads.
                            s_we       <= 1'b0;
                            s_addr     <= m0_addr;
                            s_wdata    <= '0;
                            s_wstrb    <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                StReq: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (s_gnt) begin
                        s_req <= 1'b0;
                        state <= StResp;
                    end else if (tmo_hit) begin
                        s_req <= 1'b0;
                        state <= StIdle;
                    end
                end
                StResp: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (s_rvalid || tmo_hit) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    s_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a behavioural slave, a grant and
// response monitor backed by an expected-response queue, and one task per
// scenario.
module tb_sram_port_arbiter;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_gnt, m0_rvalid, m0_rerr;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;

    // Slave model controls and state.
    logic        slave_en = 1'b1;
    int          gnt_delay = 0;
    int          rsp_delay = 1;
    logic        rsp_never = 1'b0;
    logic        sl_gnt = 1'b0, sl_rvalid = 1'b0;
    logic [31:0] sl_rdata = '0;
    logic        man_gnt = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    int          sl_gcnt = 0, sl_rcnt = 0;
    logic        sl_pend = 1'b0;
    logic [31:0] sl_pdata = '0;

    exp_t        exp_q[$];
    int          gnt_log[$];
    int          gnt_cycles[$];
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    assign s_gnt    = slave_en ? sl_gnt : man_gnt;
    assign s_rvalid = slave_en ? sl_rvalid : man_rvalid;
    assign s_rdata  = slave_en ? sl_rdata : man_rdata;

    sram_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIM(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'h5A5A_00FF);
    endfunction

    // Slave: grants after gnt_delay cycles of s_req, responds rsp_delay later.
    always @(posedge clk) begin
        #1;
        if (slave_en) begin
            sl_gnt    = 1'b0;
            sl_rvalid = 1'b0;
            sl_rdata  = '0;
            if (sl_pend) begin
                if (sl_rcnt == rsp_delay) begin
                    sl_rvalid = 1'b1;
                    sl_rdata  = sl_pdata;
                    sl_pend   = 1'b0;
                end else begin
                    sl_rcnt++;
                end
            end else if (s_req) begin
                if (sl_gcnt == gnt_delay) begin
                    sl_gnt   = 1'b1;
                    sl_gcnt  = 0;
                    sl_pend  = !rsp_never;
                    sl_rcnt  = 1;
                    sl_pdata = model(s_addr);
                end else begin
                    sl_gcnt++;
                end
            end
        end
    end

    // Monitor: log grants, queue the expected response, score each response.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] gd;
        if (!rst) begin
            if (m0_gnt || m1_gnt) begin
                gnt_log.push_back(m1_gnt ? 1 : 0);
                gnt_cycles.push_back(cyc);
                e.who  = m1_gnt;
                e.err  = rsp_never;
                e.data = rsp_never ? 32'h0 : model(m1_gnt ? m1_addr : m0_addr);
                exp_q.push_back(e);
                checks++;
                if (m0_gnt && m1_gnt) begin
                    errors++;
                    $display("FAIL dual_grant: got m0_gnt=1 m1_gnt=1, expected one");
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                rsp_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_rvalid: got rvalid m0=%b m1=%b, expected none",
                             m0_rvalid, m1_rvalid);
                end else begin
                    e  = exp_q.pop_front();
                    gd = m1_rvalid ? m1_rdata : m0_rdata;
                    if ((m0_rvalid && m1_rvalid) || m1_rvalid !== e.who || gd !== e.data ||
                        (m1_rvalid ? m1_rerr : m0_rerr) !== e.err ||
                        (m1_rvalid ? m0_rdata : m1_rdata) !== 32'h0) begin
                        errors++;
                        $display("FAIL response: got m1=%b data=%h err=%b, expected m1=%b data=%h err=%b",
                                 m1_rvalid, gd, m1_rvalid ? m1_rerr : m0_rerr,
                                 e.who, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic wait_rvalid(input int budget, output int cycles);
        cycles = 0;
        while (!(m0_rvalid || m1_rvalid) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0ABC;
        repeat (2) @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b, expected 0", m0_gnt);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_req, s_we, s_addr, s_wdata, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_slave_side: got req=%b we=%b addr=%h wdata=%h wstrb=%h, expected all 0",
                     s_req, s_we, s_addr, s_wdata, s_wstrb);
        end
        checks++;
        if ({m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_master_side: got %b, expected 000000",
                     {m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr});
        end
    endtask

    task automatic test_fetch;
        int c;
        @(posedge clk); #1;
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt: got m0=%b m1=%b, expected m0=1 m1=0", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0 || s_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL fetch_sreq: got req=%b addr=%h we=%b wstrb=%h, expected 1 00000100 0 0",
                     s_req, s_addr, s_we, s_wstrb);
        end
        wait_rvalid(1, c);
        checks++;
        if (c !== 1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h13 || m0_rerr !== 1'b0 ||
            m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_rsp: got wait=%0d rvalid=%b rdata=%h rerr=%b m1_rvalid=%b, expected 1 1 00000013 0 0",
                     c, m0_rvalid, m0_rdata, m0_rerr, m1_rvalid);
        end
    endtask

    task automatic test_simultaneous;
        int c;
        @(posedge clk); #1;
        m0_req   = 1'b1;
        m0_addr  = 32'h0000_0200;
        m1_req   = 1'b1;
        m1_we    = 1'b1;
        m1_addr  = 32'h8000_0000;
        m1_wdata = 32'hDEAD_BEEF;
        m1_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL simul_first: got m0=%b m1=%b, expected m0=0 m1=1", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        m1_we  = 1'b0;
        @(negedge clk);
        checks++;
        if (s_we !== 1'b1 || s_wdata !== 32'hDEAD_BEEF || s_addr !== 32'h8000_0000 ||
            s_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL simul_write: got we=%b wdata=%h addr=%h wstrb=%h, expected 1 deadbeef 80000000 f",
                     s_we, s_wdata, s_addr, s_wstrb);
        end
        wait_rvalid(20, c);
        checks++;
        if (m1_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL simul_m1_rsp: got %b after %0d cycles, expected 1", m1_rvalid, c);
        end
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL simul_second: got m0_gnt=%b, expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (s_we !== 1'b0 || s_wstrb !== 4'h0 || s_addr !== 32'h200) begin
            errors++;
            $display("FAIL simul_fetch_read: got we=%b wstrb=%h addr=%h, expected 0 0 00000200",
                     s_we, s_wstrb, s_addr);
        end
        wait_rvalid(20, c);
        checks++;
        if (m0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL simul_m0_rsp: got %b, expected 1", m0_rvalid);
        end
    endtask

    task automatic test_starvation;
        int n;
        int exp_order[6] = '{1, 1, 1, 1, 0, 1};
        logic ok;
        @(posedge clk); #1;
        gnt_log.delete();
        m0_req  = 1'b1;
        m0_addr = 32'h0000_1000;
        m1_req  = 1'b1;
        m1_we   = 1'b0;
        m1_addr = 32'h0000_2000;
        n = 0;
        while (gnt_log.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (m0_gnt) begin
                @(negedge clk);
                n++;
                checks++;
                if (dut.starve_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL starve_clear: got %0d, expected 0", dut.starve_cnt);
                end
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        ok = (gnt_log.size() >= 6);
        for (int i = 0; i < 6 && ok; i++) begin
            if (gnt_log[i] != exp_order[i]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL starve_order: got %p, expected M1 M1 M1 M1 M0 M1 (1 1 1 1 0 1)", gnt_log);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        int hi, bad, c, r0;
        gnt_delay = 5;
        rsp_delay = 3;
        @(posedge clk); #1;
        m1_req  = 1'b1;
        m1_we   = 1'b0;
        m1_addr = 32'h0000_0040;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stall_gnt: got %b, expected 1", m1_gnt);
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        r0 = rsp_cnt;
        @(negedge clk);
        hi  = 0;
        bad = 0;
        while (s_req && hi < 20) begin
            hi++;
            if (s_addr !== 32'h40) bad++;
            @(negedge clk);
        end
        checks++;
        if (hi != 6 || bad != 0) begin
            errors++;
            $display("FAIL stall_sreq: got %0d cycles, %0d addr changes, expected 6, 0", hi, bad);
        end
        wait_rvalid(10, c);
        checks++;
        if (c != 2 || m1_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_rsp: got wait=%0d rvalid=%b, expected 2 1", c, m1_rvalid);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_cnt - r0 != 1) begin
            errors++;
            $display("FAIL stall_single: got %0d responses, expected 1", rsp_cnt - r0);
        end
        gnt_delay = 0;
        rsp_delay = 1;
    endtask

    task automatic test_timeout;
        int c;
        rsp_never = 1'b1;
        @(posedge clk); #1;
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0300;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL tmo_gnt: got %b, expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        // First REQ cycle is c=0, so the 16th REQ+RESP cycle is c=15.
        wait_rvalid(40, c);
        checks++;
        if (c != 15 || m0_rvalid !== 1'b1 || m0_rerr !== 1'b1 || m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_err: got wait=%0d rvalid=%b rerr=%b rdata=%h, expected 15 1 1 0",
                     c, m0_rvalid, m0_rerr, m0_rdata);
        end
        @(posedge clk); #1;
        rsp_never = 1'b0;
        m1_req    = 1'b1;
        m1_we     = 1'b0;
        m1_addr   = 32'h0000_0044;
        @(negedge clk);
        checks++;
        if (s_req !== 1'b0 || m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL tmo_recover_gnt: got s_req=%b m1_gnt=%b, expected 0 1", s_req, m1_gnt);
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        wait_rvalid(20, c);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rerr !== 1'b0 || m1_rdata !== model(32'h44)) begin
            errors++;
            $display("FAIL tmo_recover_rsp: got rvalid=%b rerr=%b rdata=%h, expected 1 0 %h",
                     m1_rvalid, m1_rerr, m1_rdata, model(32'h44));
        end
    endtask

    task automatic test_reset_resp;
        int c;
        @(negedge clk);
        slave_en = 1'b0;
        @(posedge clk); #1;
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0500;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstresp_gnt: got %b, expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        m0_req  = 1'b0;
        man_gnt = 1'b1;
        @(posedge clk); #1;
        man_gnt = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL rstresp_sreq: got %b, expected 0", s_req);
        end
        @(posedge clk); #1;
        man_rvalid = 1'b1;
        man_rdata  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstresp_no_rvalid: got m0=%b m1=%b, expected 0 0", m0_rvalid, m1_rvalid);
        end
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        m0_req     = 1'b1;
        m0_addr    = 32'h0000_0600;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstresp_regrant: got %b, expected 1", m0_gnt);
        end
        slave_en = 1'b1;
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        wait_rvalid(20, c);
        checks++;
        if (m0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstresp_after: got %b, expected 1", m0_rvalid);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk); #1;
        gnt_cycles.delete();
        m1_req  = 1'b1;
        m1_we   = 1'b0;
        m1_addr = 32'h0000_0080;
        n = 0;
        while (gnt_cycles.size() < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        checks++;
        if (gnt_cycles.size() < 3 || gnt_cycles[1] - gnt_cycles[0] != 3 ||
            gnt_cycles[2] - gnt_cycles[1] != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got grant cycles %p, expected spacing 3", gnt_cycles);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_stall();
        test_timeout();
        test_reset_resp();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
